// File: rtl/alu_ctrl_pipe.sv
// Registered RV32I ALU control decoder with a 2-entry skid buffer at the ID/EX boundary.
// Define ALU_CTRL_MEXT_EN to decode the M-extension (MUL..REMU) codes; it requires CTRL_W >= 5.
module alu_ctrl_pipe #(
    parameter int unsigned CTRL_W = 4,
    parameter int unsigned TAG_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [6:0]        op,
    input  logic [2:0]        funct3,
    input  logic [6:0]        funct7,
    input  logic [1:0]        ALUOp,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_alu_ctrl,
    output logic              out_illegal,
    output logic [TAG_W-1:0]  out_tag
);

`ifdef ALU_CTRL_MEXT_EN
    localparam int unsigned CodeW = 5;
`else
    localparam int unsigned CodeW = 4;
`endif

    if (CTRL_W < CodeW) begin : g_bad_ctrl_w
        $error("alu_ctrl_pipe: CTRL_W too narrow for the enabled code set");
    end

    localparam logic [4:0] CodeAdd   = 5'd0;
    localparam logic [4:0] CodeSub   = 5'd1;
    localparam logic [4:0] CodeAnd   = 5'd2;
    localparam logic [4:0] CodeOr    = 5'd3;
    localparam logic [4:0] CodeXor   = 5'd4;
    localparam logic [4:0] CodeSlt   = 5'd5;
    localparam logic [4:0] CodeSltu  = 5'd6;
    localparam logic [4:0] CodeSll   = 5'd7;
    localparam logic [4:0] CodeSrl   = 5'd8;
    localparam logic [4:0] CodeSra   = 5'd9;
    localparam logic [4:0] CodePassB = 5'd10;

    logic [4:0] dec_code;
    logic       dec_ill;
    logic       is_r;
    logic       f7_zero;
    logic       f7_alt;
    logic       unused_op;

    // Only op[5] separates R-type from I-type here; the rest is the main decoder's business.
    assign unused_op = ^{op[6], op[4:0]};
    assign is_r      = op[5];
    assign f7_zero   = (funct7 == 7'b0000000);
    assign f7_alt    = (funct7 == 7'b0100000);

    always_comb begin
        dec_code = CodeAdd;
        dec_ill  = 1'b0;
        unique case (ALUOp)
            2'b00: dec_code = CodeAdd;
            2'b01: dec_code = CodeSub;
            2'b11: dec_code = CodePassB;
            default: begin
                case (funct3)
                    3'b000: begin
                        if (is_r) begin
                            if (f7_alt) begin
                                dec_code = CodeSub;
                            end else if (!f7_zero) begin
                                dec_ill = 1'b1;
                            end
                        end
                    end
                    3'b001: begin
                        dec_code = CodeSll;
                        dec_ill  = !f7_zero;
                    end
                    3'b101: begin
                        if (f7_alt) begin
                            dec_code = CodeSra;
                        end else begin
                            dec_code = CodeSrl;
                            dec_ill  = !f7_zero;
                        end
                    end
                    default: begin
                        unique case (funct3)
                            3'b010:  dec_code = CodeSlt;
                            3'b011:  dec_code = CodeSltu;
                            3'b100:  dec_code = CodeXor;
                            3'b110:  dec_code = CodeOr;
                            default: dec_code = CodeAnd;
                        endcase
                        // I-type funct7 bits are immediate bits, so only R-type is policed.
                        dec_ill = is_r && !f7_zero;
                    end
                endcase
`ifdef ALU_CTRL_MEXT_EN
                if (is_r && (funct7 == 7'b0000001)) begin
                    dec_code = {2'b10, funct3};
                    dec_ill  = 1'b0;
                end
`endif
                if (dec_ill) begin
                    dec_code = CodeAdd;
                end
            end
        endcase
    end

    logic              out_valid_q, out_valid_d;
    logic [CTRL_W-1:0] out_ctrl_q, out_ctrl_d;
    logic              out_ill_q, out_ill_d;
    logic [TAG_W-1:0]  out_tag_q, out_tag_d;
    logic              skid_valid_q, skid_valid_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              skid_ill_q, skid_ill_d;
    logic [TAG_W-1:0]  skid_tag_q, skid_tag_d;

    always_comb begin
        out_valid_d  = out_valid_q;
        out_ctrl_d   = out_ctrl_q;
        out_ill_d    = out_ill_q;
        out_tag_d    = out_tag_q;
        skid_valid_d = skid_valid_q;
        skid_ctrl_d  = skid_ctrl_q;
        skid_ill_d   = skid_ill_q;
        skid_tag_d   = skid_tag_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!out_valid_q || out_ready) begin
            // Output register is free this cycle; skid entry (if any) is older, so it goes first.
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_ctrl_d   = skid_ctrl_q;
                out_ill_d    = skid_ill_q;
                out_tag_d    = skid_tag_q;
                skid_valid_d = 1'b0;
            end else if (in_valid) begin
                out_valid_d = 1'b1;
                out_ctrl_d  = CTRL_W'(dec_code);
                out_ill_d   = dec_ill;
                out_tag_d   = in_tag;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_valid && !skid_valid_q) begin
            skid_valid_d = 1'b1;
            skid_ctrl_d  = CTRL_W'(dec_code);
            skid_ill_d   = dec_ill;
            skid_tag_d   = in_tag;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_ctrl_q   <= '0;
            out_ill_q    <= 1'b0;
            out_tag_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_ctrl_q  <= '0;
            skid_ill_q   <= 1'b0;
            skid_tag_q   <= '0;
        end else begin
            out_valid_q  <= out_valid_d;
            out_ctrl_q   <= out_ctrl_d;
            out_ill_q    <= out_ill_d;
            out_tag_q    <= out_tag_d;
            skid_valid_q <= skid_valid_d;
            skid_ctrl_q  <= skid_ctrl_d;
            skid_ill_q   <= skid_ill_d;
            skid_tag_q   <= skid_tag_d;
        end
    end

    assign in_ready     = !skid_valid_q;
    assign out_valid    = out_valid_q;
    assign out_alu_ctrl = out_ctrl_q;
    assign out_illegal  = out_ill_q;
    assign out_tag      = out_tag_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed scenarios plus randomized traffic
// compared against a queue-based transaction model.
module tb_alu_ctrl_pipe;

`ifdef ALU_CTRL_MEXT_EN
    localparam int unsigned CTRL_W = 5;
    localparam bit Mext = 1'b1;
`else
    localparam int unsigned CTRL_W = 4;
    localparam bit Mext = 1'b0;
`endif
    localparam int unsigned TAG_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [6:0]        op;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [1:0]        aluop;
    logic [TAG_W-1:0]  in_tag;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_alu_ctrl;
    logic              out_illegal;
    logic [TAG_W-1:0]  out_tag;

    int checks = 0;
    int failures = 0;

    typedef struct {
        int              code;
        bit              ill;
        logic [TAG_W-1:0] tag;
    } item_t;
    item_t q[$];

    alu_ctrl_pipe #(.CTRL_W(CTRL_W), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .funct3(funct3), .funct7(funct7), .ALUOp(aluop), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_alu_ctrl(out_alu_ctrl),
        .out_illegal(out_illegal), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    // Reference decode straight from the instruction-set rules.
    function automatic void ref_decode(input logic [1:0] a, input logic [6:0] o,
                                       input logic [2:0] f3, input logic [6:0] f7,
                                       output int code, output bit ill);
        int base [8] = '{0, 7, 5, 6, 4, 8, 3, 2};
        bit r;
        r = o[5];
        ill = 1'b0;
        code = 0;
        case (a)
            2'b00: code = 0;
            2'b01: code = 1;
            2'b11: code = 10;
            default: begin
                if (Mext && r && f7 == 7'h01) begin
                    code = 16 + int'(f3);
                end else begin
                    if (r && !(f7 inside {7'h00, 7'h20})) ill = 1'b1;
                    if (r && f7 == 7'h20 && !(f3 inside {3'd0, 3'd5})) ill = 1'b1;
                    if (f3 == 3'd1 && f7 != 7'h00) ill = 1'b1;
                    if (f3 == 3'd5 && !(f7 inside {7'h00, 7'h20})) ill = 1'b1;
                    code = base[f3];
                    if (f7 == 7'h20 && f3 == 3'd0 && r) code = 1;
                    if (f7 == 7'h20 && f3 == 3'd5) code = 9;
                    if (ill) code = 0;
                end
            end
        endcase
    endfunction

    // One clock: update the transaction model with the values that were on the inputs.
    task automatic cycle();
        bit acc, drn;
        item_t it;
        @(posedge clk);
        acc = in_valid && (q.size() < 2);
        drn = out_ready && (q.size() > 0);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                ref_decode(aluop, op, funct3, funct7, it.code, it.ill);
                it.tag = in_tag;
                q.push_back(it);
            end
        end
        #1;
    endtask

    task automatic send(input logic [1:0] a, input logic [6:0] o, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [TAG_W-1:0] t);
        in_valid = 1'b1;
        aluop = a;
        op = o;
        funct3 = f3;
        funct7 = f7;
        in_tag = t;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        out_ready = 1'b0;
        send(2'b10, 7'b0110011, 3'b100, 7'h00, 8'h77);
        cycle();
        send(2'b10, 7'b0110011, 3'b110, 7'h00, 8'h78);
        cycle();
        idle();
        #2 rst = 1'b1;
        q.delete();
        #1;
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_async_valid: got %b want 0", out_valid);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_alu_ctrl !== '0 || out_illegal !== 1'b0 ||
            out_tag !== '0) begin
            failures++;
            $display("FAIL reset_outputs: valid=%b ctrl=%0h ill=%b tag=%0h want all 0",
                     out_valid, out_alu_ctrl, out_illegal, out_tag);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_after_edge: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_decode_add_sub();
        out_ready = 1'b1;
        send(2'b10, 7'b0110011, 3'b000, 7'b0100000, 8'h12);
        cycle();
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_alu_ctrl !== CTRL_W'(1) || out_illegal !== 1'b0 ||
            out_tag !== 8'h12) begin
            failures++;
            $display("FAIL sub_rtype: valid=%b ctrl=%0h ill=%b tag=%0h want 1/1/0/12",
                     out_valid, out_alu_ctrl, out_illegal, out_tag);
        end
        send(2'b10, 7'b0010011, 3'b000, 7'b0100000, 8'h13);
        cycle();
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_alu_ctrl !== CTRL_W'(0) || out_illegal !== 1'b0 ||
            out_tag !== 8'h13) begin
            failures++;
            $display("FAIL addi_f7_ignored: valid=%b ctrl=%0h ill=%b tag=%0h want 1/0/0/13",
                     out_valid, out_alu_ctrl, out_illegal, out_tag);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty: got %b want 0", out_valid);
        end
    endtask

    task automatic test_shift_illegal();
        out_ready = 1'b1;
        send(2'b10, 7'b0110011, 3'b101, 7'b0100000, 8'h21);
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_alu_ctrl !== CTRL_W'(9) || out_illegal !== 1'b0) begin
            failures++;
            $display("FAIL sra: valid=%b ctrl=%0h ill=%b want 1/9/0",
                     out_valid, out_alu_ctrl, out_illegal);
        end
        send(2'b10, 7'b0110011, 3'b001, 7'b0100000, 8'h22);
        cycle();
        idle();
        checks++;
        if (out_valid !== 1'b1 || out_alu_ctrl !== CTRL_W'(0) || out_illegal !== 1'b1 ||
            out_tag !== 8'h22) begin
            failures++;
            $display("FAIL sll_bad_f7: valid=%b ctrl=%0h ill=%b tag=%0h want 1/0/1/22",
                     out_valid, out_alu_ctrl, out_illegal, out_tag);
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        send(2'b00, 7'b0110011, 3'b000, 7'h00, 8'd1);
        cycle();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_tag !== 8'd1) begin
            failures++;
            $display("FAIL bp_first: ready=%b valid=%b tag=%0d want 1/1/1",
                     in_ready, out_valid, out_tag);
        end
        send(2'b01, 7'b0110011, 3'b000, 7'h00, 8'd2);
        cycle();
        idle();
        checks++;
        if (in_ready !== 1'b0 || out_tag !== 8'd1) begin
            failures++;
            $display("FAIL bp_skid_full: ready=%b tag=%0d want 0/1", in_ready, out_tag);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 8'd1 || out_alu_ctrl !== CTRL_W'(0)) begin
            failures++;
            $display("FAIL bp_hold: valid=%b tag=%0d ctrl=%0h want 1/1/0",
                     out_valid, out_tag, out_alu_ctrl);
        end
        out_ready = 1'b1;
        #1;
        checks++;
        if (out_tag !== 8'd1) begin
            failures++;
            $display("FAIL bp_present1: tag=%0d want 1", out_tag);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 8'd2 || out_alu_ctrl !== CTRL_W'(1) ||
            in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_present2: valid=%b tag=%0d ctrl=%0h ready=%b want 1/2/1/1",
                     out_valid, out_tag, out_alu_ctrl, in_ready);
        end
        cycle();
        checks++;
        if (out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_empty: valid=%b want 0", out_valid);
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        send(2'b11, 7'b0110011, 3'b000, 7'h00, 8'd3);
        cycle();
        send(2'b11, 7'b0110011, 3'b000, 7'h00, 8'd4);
        cycle();
        send(2'b11, 7'b0110011, 3'b000, 7'h00, 8'd5);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_full: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle();
            checks++;
            if (out_valid !== 1'b0) begin
                failures++;
                $display("FAIL flush_ghost: cycle %0d valid=%b tag=%0d want valid 0",
                         i, out_valid, out_tag);
            end
        end
        out_ready = 1'b0;
        send(2'b00, 7'b0110011, 3'b000, 7'h00, 8'd6);
        cycle();
        send(2'b00, 7'b0110011, 3'b000, 7'h00, 8'd7);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        idle();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_accept: valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_mext();
        out_ready = 1'b1;
        send(2'b10, 7'b0110011, 3'b100, 7'b0000001, 8'h44);
        cycle();
        idle();
        checks++;
        if (Mext) begin
            if (out_valid !== 1'b1 || out_alu_ctrl !== CTRL_W'(20) || out_illegal !== 1'b0) begin
                failures++;
                $display("FAIL mext_div: valid=%b ctrl=%0h ill=%b want 1/14/0",
                         out_valid, out_alu_ctrl, out_illegal);
            end
        end else begin
            if (out_valid !== 1'b1 || out_alu_ctrl !== CTRL_W'(0) || out_illegal !== 1'b1) begin
                failures++;
                $display("FAIL mext_off: valid=%b ctrl=%0h ill=%b want 1/0/1",
                         out_valid, out_alu_ctrl, out_illegal);
            end
        end
        cycle();
    endtask

    task automatic test_random();
        logic [6:0] f7_pick [4] = '{7'h00, 7'h20, 7'h01, 7'h00};
        logic [CTRL_W-1:0] exp_code;
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            aluop     = 2'($urandom_range(0, 3));
            op        = $urandom_range(0, 1) ? 7'b0110011 :
                        ($urandom_range(0, 1) ? 7'b0010011 : 7'($urandom));
            funct3    = 3'($urandom);
            funct7    = ($urandom_range(0, 4) == 0) ? 7'($urandom) : f7_pick[$urandom_range(0, 3)];
            in_tag    = 8'($urandom);
            cycle();
            checks++;
            if (out_valid !== (q.size() > 0)) begin
                failures++;
                $display("FAIL rand_valid: step %0d got %b want %b", i, out_valid, q.size() > 0);
            end
            checks++;
            if (in_ready !== (q.size() < 2)) begin
                failures++;
                $display("FAIL rand_ready: step %0d got %b want %b", i, in_ready, q.size() < 2);
            end
            if (q.size() > 0) begin
                exp_code = CTRL_W'(q[0].code);
                checks++;
                if (out_alu_ctrl !== exp_code || out_illegal !== q[0].ill ||
                    out_tag !== q[0].tag) begin
                    failures++;
                    $display("FAIL rand_data: step %0d got ctrl=%0h ill=%b tag=%0h want %0h/%b/%0h",
                             i, out_alu_ctrl, out_illegal, out_tag, exp_code, q[0].ill, q[0].tag);
                end
            end
        end
        flush = 1'b0;
        idle();
    endtask

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        op = '0;
        funct3 = '0;
        funct7 = '0;
        aluop = '0;
        in_tag = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_decode_add_sub();
        test_shift_illegal();
        test_back_to_back();
        test_flush();
        test_mext();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
